// File: rtl/ram_port_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : ram_port_arbiter_pkg
// Brief    : Shared constants and types for the RAM port arbiter slice.
//            Optional build macro: RAM_PORT_ARBITER_FIXED_PRIO_EN
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ram_port_arbiter_pkg;

  // Default geometry of the shared RAM and requester count
  localparam int c_ADDR_W    = 10;
  localparam int c_DATA_W    = 8;
  localparam int c_N_REQ     = 2;

  // The index type is sized for the largest supported requester count so one
  // type serves every legal N_REQ
  localparam int c_N_REQ_MAX = 8;
  localparam int REQ_ID_W    = $clog2(c_N_REQ_MAX);

  typedef logic [REQ_ID_W-1:0] req_idx_t;

endpackage

`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : ram_port_arbiter_if
// Brief    : Requester-side request/response bundle of the RAM port arbiter.
//            Optional build macro: RAM_PORT_ARBITER_FIXED_PRIO_EN (no effect here)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ram_port_arbiter_if
  import ram_port_arbiter_pkg::*;
#(
  parameter int N_REQ  = c_N_REQ,
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;

  // Client side: issues requests, consumes grants and responses
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

`default_nettype wire

// File: rtl/ram_port_arbiter_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Combinational grant selection. Round-robin search starting just
//            after i_ptr by default; lowest-index-wins fixed priority when
//            RAM_PORT_ARBITER_FIXED_PRIO_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int N_REQ = c_N_REQ
) (
  input  wire logic [N_REQ-1:0] i_req,
  input  wire req_idx_t         i_ptr,
  output logic [N_REQ-1:0]      o_grant,
  output req_idx_t              o_winner,
  output logic                  o_any
);

`ifdef RAM_PORT_ARBITER_FIXED_PRIO_EN
  // Pointer has no meaning under fixed priority
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  // Scan from the top down so the lowest requesting index is left standing
  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    o_any    = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_winner   = req_idx_t'(i);
        o_any      = 1'b1;
      end
    end
  end
`else
  // Two ascending passes: first the indices above the pointer, then the
  // wrapped-around ones up to and including the pointer itself
  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    o_any    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!o_any && (i > int'(i_ptr)) && i_req[i]) begin
        o_grant[i] = 1'b1;
        o_winner   = req_idx_t'(i);
        o_any      = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!o_any && (i <= int'(i_ptr)) && i_req[i]) begin
        o_grant[i] = 1'b1;
        o_winner   = req_idx_t'(i);
        o_any      = 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : ram_port_arbiter
// Brief    : Shares one single-port synchronous RAM (1-cycle read latency)
//            between N_REQ requesters, one access per cycle, read data routed
//            back to the issuer. Build macro RAM_PORT_ARBITER_FIXED_PRIO_EN
//            selects fixed priority instead of round-robin.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DATA_W = c_DATA_W,
  parameter int N_REQ  = c_N_REQ
) (
  input  wire logic              clk,
  input  wire logic              rst,
  ram_port_arbiter_if.slave      bus,
  output logic                   ram_we,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_din,
  input  wire logic [DATA_W-1:0] ram_dout
);

  localparam req_idx_t c_PTR_RST = req_idx_t'(N_REQ - 1);

  req_idx_t          w_ptr;
  logic [N_REQ-1:0]  w_grant;
  req_idx_t          w_winner;
  logic              w_any;
  logic              w_issue;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_hold_din;
  logic              r_rd_pending;
  req_idx_t          r_rd_id;
  logic [N_REQ-1:0]  w_rd_onehot;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  rr_arbiter #(
    .N_REQ    (N_REQ)
  ) u_arb (
    .i_req    (bus.req_valid),
    .i_ptr    (w_ptr),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

`ifdef RAM_PORT_ARBITER_FIXED_PRIO_EN
  assign w_ptr = c_PTR_RST;
`else
  req_idx_t r_last_grant;

  // Remember the most recent winner so the next search starts after it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= c_PTR_RST;
    end else if (w_any) begin
      r_last_grant <= w_winner;
    end
  end

  assign w_ptr = r_last_grant;
`endif

  // Select the winning requester's payload (grant is one-hot)
  always_comb begin
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_win_we    = bus.req_we[i];
        w_win_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_win_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // No access is issued while reset is held, even if requests are present
  assign w_issue       = w_any & ~rst;
  assign bus.req_ready = rst ? '0 : w_grant;
  assign ram_we        = w_issue & w_win_we;
  assign ram_addr      = w_issue ? w_win_addr  : r_hold_addr;
  assign ram_din       = w_issue ? w_win_wdata : r_hold_din;

  // Keep the last issued address/data so the RAM pins stay quiet when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_addr <= '0;
      r_hold_din  <= '0;
    end else if (w_any) begin
      r_hold_addr <= w_win_addr;
      r_hold_din  <= w_win_wdata;
    end
  end

  // Track an accepted read and who issued it while the RAM fetches the word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_pending <= 1'b0;
      r_rd_id      <= '0;
    end else begin
      r_rd_pending <= w_any & ~w_win_we;
      r_rd_id      <= w_winner;
    end
  end

  // Decode the pending read's owner into the response strobe
  always_comb begin
    w_rd_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_rd_onehot[i] = r_rd_pending && (r_rd_id == req_idx_t'(i));
    end
  end

  // Register the response pulse together with the RAM output word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_rd_onehot;
      if (r_rd_pending) begin
        r_rsp_rdata <= ram_dout;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_ram_port_arbiter
// Brief    : Directed vector bench for ram_port_arbiter with a behavioural
//            1-cycle-latency RAM. Honors RAM_PORT_ARBITER_FIXED_PRIO_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int c_AW = 10;
  localparam int c_DW = 8;
  localparam int c_NR = 2;
  localparam int c_NV = 16;

  logic            clk;
  logic            rst;
  logic            ram_we;
  logic [c_AW-1:0] ram_addr;
  logic [c_DW-1:0] ram_din;
  logic [c_DW-1:0] ram_dout;
  logic [c_DW-1:0] mem [0:(1<<c_AW)-1];

  int total = 0;
  int bad   = 0;

  ram_port_arbiter_if #(.N_REQ(c_NR), .ADDR_W(c_AW), .DATA_W(c_DW)) bus ();

  ram_port_arbiter #(
    .ADDR_W   (c_AW),
    .DATA_W   (c_DW),
    .N_REQ    (c_NR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM, one-cycle read latency
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic [1:0] valid;
    logic [1:0] we;
    logic [9:0] a0;
    logic [9:0] a1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] e_ready;
    logic       e_we;
    logic [9:0] e_addr;
    logic [7:0] e_din;
    logic [1:0] e_rsp;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t tbl [c_NV];

  function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] we,
                              input logic [9:0] a0, input logic [9:0] a1,
                              input logic [7:0] d0, input logic [7:0] d1,
                              input logic [1:0] e_ready, input logic e_we,
                              input logic [9:0] e_addr, input logic [7:0] e_din,
                              input logic [1:0] e_rsp, input logic [7:0] e_rdata);
    vec_t v;
    v.valid = valid; v.we = we; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.e_ready = e_ready; v.e_we = e_we; v.e_addr = e_addr; v.e_din = e_din;
    v.e_rsp = e_rsp; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive all requester inputs at the falling edge, settle 1 time unit
  task automatic drive(input logic [1:0] valid, input logic [1:0] we,
                       input logic [9:0] a0, input logic [9:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clk);
    bus.req_valid = valid;
    bus.req_we    = we;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
    #1;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 10'd0, 10'd0, 8'd0, 8'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << c_AW); i++) mem[i] = '0;

    // Directed vectors; rsp column reflects the read accepted two rows earlier
    tbl[0]  = mk(2'b01, 2'b01, 10'd55, 10'd0,  8'h56, 8'h00, 2'b01, 1'b1, 10'd55, 8'h56, 2'b00, 8'h00);
    tbl[1]  = mk(2'b01, 2'b00, 10'd55, 10'd0,  8'h00, 8'h00, 2'b01, 1'b0, 10'd55, 8'h00, 2'b00, 8'h00);
    tbl[2]  = mk(2'b00, 2'b00, 10'd0,  10'd0,  8'h00, 8'h00, 2'b00, 1'b0, 10'd55, 8'h00, 2'b00, 8'h00);
`ifdef RAM_PORT_ARBITER_FIXED_PRIO_EN
    tbl[3]  = mk(2'b11, 2'b00, 10'd55, 10'd66, 8'h00, 8'h00, 2'b01, 1'b0, 10'd55, 8'h00, 2'b01, 8'h56);
    tbl[4]  = mk(2'b11, 2'b00, 10'd55, 10'd66, 8'h00, 8'h00, 2'b01, 1'b0, 10'd55, 8'h00, 2'b00, 8'h00);
    tbl[5]  = mk(2'b11, 2'b00, 10'd55, 10'd66, 8'h00, 8'h00, 2'b01, 1'b0, 10'd55, 8'h00, 2'b01, 8'h56);
    tbl[6]  = mk(2'b11, 2'b00, 10'd55, 10'd66, 8'h00, 8'h00, 2'b01, 1'b0, 10'd55, 8'h00, 2'b01, 8'h56);
    tbl[7]  = mk(2'b00, 2'b00, 10'd0,  10'd0,  8'h00, 8'h00, 2'b00, 1'b0, 10'd55, 8'h00, 2'b01, 8'h56);
    tbl[8]  = mk(2'b00, 2'b00, 10'd0,  10'd0,  8'h00, 8'h00, 2'b00, 1'b0, 10'd55, 8'h00, 2'b01, 8'h56);
`else
    tbl[3]  = mk(2'b11, 2'b00, 10'd55, 10'd66, 8'h00, 8'h00, 2'b10, 1'b0, 10'd66, 8'h00, 2'b01, 8'h56);
    tbl[4]  = mk(2'b11, 2'b00, 10'd55, 10'd66, 8'h00, 8'h00, 2'b01, 1'b0, 10'd55, 8'h00, 2'b00, 8'h00);
    tbl[5]  = mk(2'b11, 2'b00, 10'd55, 10'd66, 8'h00, 8'h00, 2'b10, 1'b0, 10'd66, 8'h00, 2'b10, 8'h00);
    tbl[6]  = mk(2'b11, 2'b00, 10'd55, 10'd66, 8'h00, 8'h00, 2'b01, 1'b0, 10'd55, 8'h00, 2'b01, 8'h56);
    tbl[7]  = mk(2'b00, 2'b00, 10'd0,  10'd0,  8'h00, 8'h00, 2'b00, 1'b0, 10'd55, 8'h00, 2'b10, 8'h00);
    tbl[8]  = mk(2'b00, 2'b00, 10'd0,  10'd0,  8'h00, 8'h00, 2'b00, 1'b0, 10'd55, 8'h00, 2'b01, 8'h56);
`endif
    tbl[9]  = mk(2'b00, 2'b00, 10'd0,  10'd0,  8'h00, 8'h00, 2'b00, 1'b0, 10'd55, 8'h00, 2'b00, 8'h00);
    tbl[10] = mk(2'b00, 2'b00, 10'd0,  10'd0,  8'h00, 8'h00, 2'b00, 1'b0, 10'd55, 8'h00, 2'b00, 8'h00);
    tbl[11] = mk(2'b00, 2'b00, 10'd0,  10'd0,  8'h00, 8'h00, 2'b00, 1'b0, 10'd55, 8'h00, 2'b00, 8'h00);
    tbl[12] = mk(2'b10, 2'b10, 10'd0,  10'd77, 8'h00, 8'hA5, 2'b10, 1'b1, 10'd77, 8'hA5, 2'b00, 8'h00);
    tbl[13] = mk(2'b10, 2'b00, 10'd0,  10'd77, 8'h00, 8'h00, 2'b10, 1'b0, 10'd77, 8'h00, 2'b00, 8'h00);
    tbl[14] = mk(2'b00, 2'b00, 10'd0,  10'd0,  8'h00, 8'h00, 2'b00, 1'b0, 10'd77, 8'h00, 2'b00, 8'h00);
    tbl[15] = mk(2'b00, 2'b00, 10'd0,  10'd0,  8'h00, 8'h00, 2'b00, 1'b0, 10'd77, 8'h00, 2'b10, 8'hA5);

    // Reset state, with live requests that must not be granted
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_we    = 2'b11;
    bus.req_addr  = {10'd300, 10'd200};
    bus.req_wdata = {8'hCC, 8'hBB};
    @(negedge clk);
    #1;
    chk("rst ready",  32'(bus.req_ready), 32'h0);
    chk("rst ram_we", 32'(ram_we),        32'h0);
    chk("rst addr",   32'(ram_addr),      32'h0);
    chk("rst din",    32'(ram_din),       32'h0);
    chk("rst rspv",   32'(bus.rsp_valid), 32'h0);
    chk("rst rdata",  32'(bus.rsp_rdata), 32'h0);
    bus.req_valid = 2'b00;
    bus.req_we    = 2'b00;
    rst = 1'b0;

    // Table: write/read, contention, idle run, lone requester 1
    for (int i = 0; i < c_NV; i++) begin
      drive(tbl[i].valid, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      chk($sformatf("v%0d ready", i),  32'(bus.req_ready), 32'(tbl[i].e_ready));
      chk($sformatf("v%0d ram_we", i), 32'(ram_we),        32'(tbl[i].e_we));
      chk($sformatf("v%0d addr", i),   32'(ram_addr),      32'(tbl[i].e_addr));
      chk($sformatf("v%0d din", i),    32'(ram_din),       32'(tbl[i].e_din));
      chk($sformatf("v%0d rspv", i),   32'(bus.rsp_valid), 32'(tbl[i].e_rsp));
      if (tbl[i].e_rsp != 2'b00)
        chk($sformatf("v%0d rdata", i), 32'(bus.rsp_rdata), 32'(tbl[i].e_rdata));
    end

    // Collision: write and read of 66 in the same cycle, fresh from reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(2'b11, 2'b01, 10'd66, 10'd66, 8'h36, 8'h00);
    chk("col ready0", 32'(bus.req_ready), 32'h1);
    chk("col we0",    32'(ram_we),        32'h1);
    chk("col addr0",  32'(ram_addr),      32'd66);
    chk("col din0",   32'(ram_din),       32'h36);
    drive(2'b10, 2'b00, 10'd66, 10'd66, 8'h36, 8'h00);
    chk("col ready1", 32'(bus.req_ready), 32'h2);
    chk("col we1",    32'(ram_we),        32'h0);
    chk("col addr1",  32'(ram_addr),      32'd66);
    idle();
    chk("col rspv0",  32'(bus.rsp_valid), 32'h0);
    idle();
    chk("col rspv1",  32'(bus.rsp_valid), 32'h2);
    chk("col rdata",  32'(bus.rsp_rdata), 32'h36);

    // Reset lands between read acceptance and its response
    drive(2'b01, 2'b00, 10'd55, 10'd0, 8'h00, 8'h00);
    chk("mrd ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst = 1'b1;
    #1;
    chk("mrd rspv async", 32'(bus.rsp_valid), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("mrd rspv%0d", k), 32'(bus.rsp_valid), 32'h0);
      chk($sformatf("mrd addr%0d", k), 32'(ram_addr),      32'h0);
    end
    rst = 1'b0;
    idle();
    chk("mrd rspv post", 32'(bus.rsp_valid), 32'h0);
    drive(2'b11, 2'b00, 10'd55, 10'd66, 8'h00, 8'h00);
    chk("mrd first", 32'(bus.req_ready), 32'h1);
    drive(2'b10, 2'b00, 10'd55, 10'd66, 8'h00, 8'h00);
    chk("mrd second", 32'(bus.req_ready), 32'h2);
    idle();
    chk("mrd rsp0v", 32'(bus.rsp_valid), 32'h1);
    chk("mrd rsp0d", 32'(bus.rsp_rdata), 32'h56);
    idle();
    chk("mrd rsp1v", 32'(bus.rsp_valid), 32'h2);
    chk("mrd rsp1d", 32'(bus.rsp_rdata), 32'h36);
    idle();
    chk("mrd rsp2v", 32'(bus.rsp_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
